// File: rtl/bram_sp.sv
// Single-port synchronous block RAM with a registered read port, read-first on collisions.
// Out-of-range addresses (possible only when SIZE is not a power of two) read as zero and never write.
module bram_sp #(
  parameter  int DATA = 32,
  parameter  int SIZE = 65536,
  localparam int ADDR = $clog2(SIZE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            write_enable,
  input  logic [DATA-1:0] data,
  input  logic [ADDR-1:0] addr,
  output logic [DATA-1:0] data_out
);

  // One extra bit so SIZE itself is representable when SIZE == 2**ADDR.
  localparam logic [ADDR:0] SIZE_W = SIZE[ADDR:0];

  // The zero fill gives defined reads before any write; rst never clears the array.
  logic [DATA-1:0] mem [SIZE] = '{default: '0};

  logic in_range;

  assign in_range = {1'b0, addr} < SIZE_W;

  // NOTE: non-blocking on both mem and data_out makes the read return the pre-write word
  // (read-first), and keeping them in one block lets synthesis fold data_out into the BRAM
  // output register with its reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
    end else begin
      if (write_enable && in_range) begin
        mem[addr] <= data;
      end
      data_out <= in_range ? mem[addr] : '0;
    end
  end

endmodule

// File: tb/tb_bram_sp.sv
// Scoreboard bench for bram_sp: a full-size instance (SIZE=65536) and a non-power-of-two
// instance (SIZE=10) exercising reset, read-first collisions, boundaries and out-of-range access.
module tb_bram_sp;

  localparam int DATA   = 32;
  localparam int SIZE_B = 65536;
  localparam int SIZE_S = 10;

  logic        clk = 1'b0;
  logic        rst_b, we_b, rst_s, we_s;
  logic [31:0] data_b, data_s, dout_b, dout_s;
  logic [15:0] addr_b;
  logic [3:0]  addr_s;

  typedef struct packed {
    logic        tgt;   // 0 = full-size DUT, 1 = SIZE=10 DUT
    logic        chk;
    logic [31:0] exp;
  } exp_t;

  exp_t  exp_q [$];
  string name_q [$];
  int    checks   = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  bram_sp #(.DATA(DATA), .SIZE(SIZE_B)) u_big (
    .clk          (clk),
    .rst          (rst_b),
    .write_enable (we_b),
    .data         (data_b),
    .addr         (addr_b),
    .data_out     (dout_b)
  );

  bram_sp #(.DATA(DATA), .SIZE(SIZE_S)) u_small (
    .clk          (clk),
    .rst          (rst_s),
    .write_enable (we_s),
    .data         (data_s),
    .addr         (addr_s),
    .data_out     (dout_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue what data_out must show after the next edge.
  task automatic step(input logic tgt, input logic r, input logic we, input logic [15:0] a,
                      input logic [31:0] d, input logic chk, input logic [31:0] exp,
                      input string name);
    exp_t e;
    @(negedge clk);
    rst_b = 1'b0; we_b = 1'b0; rst_s = 1'b0; we_s = 1'b0;
    if (tgt == 1'b0) begin
      rst_b = r; we_b = we; addr_b = a; data_b = d;
    end else begin
      rst_s = r; we_s = we; addr_s = a[3:0]; data_s = d;
    end
    e.tgt = tgt; e.chk = chk; e.exp = exp;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  // Monitor: one queued expectation retires per rising edge, sampled 1ns after the edge.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (e.chk) check(n, e.tgt ? dout_s : dout_b, e.exp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_b = 1'b0; we_b = 1'b0; addr_b = '0; data_b = '0;
    rst_s = 1'b0; we_s = 1'b0; addr_s = '0; data_s = '0;

    // Reset and power-up reads on the full-size instance.
    step(0, 1, 0, 16'h0000, 32'h0, 1, 32'h0, "reset_cycle0");
    step(0, 1, 0, 16'h0000, 32'h0, 1, 32'h0, "reset_cycle1");
    step(0, 0, 0, 16'h0000, 32'h0, 1, 32'h0, "powerup_rd0");
    step(0, 0, 0, 16'h0005, 32'h0, 1, 32'h0, "powerup_rd5");
    step(0, 0, 0, 16'hFFFF, 32'h0, 1, 32'h0, "powerup_rd_top");

    // Back-to-back writes, then reads with one-cycle latency.
    step(0, 0, 1, 16'h0003, 32'hDEADBEEF, 1, 32'h0, "wr3_old");
    step(0, 0, 1, 16'h0004, 32'h12345678, 1, 32'h0, "wr4_old");
    step(0, 0, 0, 16'h0003, 32'h0, 1, 32'hDEADBEEF, "rd3");
    step(0, 0, 0, 16'h0004, 32'h12345678, 1, 32'h12345678, "rd4");
    step(0, 0, 0, 16'h0003, 32'h0, 1, 32'hDEADBEEF, "rd3_again");

    // Read-first collision on address 7.
    step(0, 0, 1, 16'h0007, 32'hAAAAAAAA, 1, 32'h0, "wr7_setup");
    step(0, 0, 1, 16'h0007, 32'h55555555, 1, 32'hAAAAAAAA, "collide7_old");
    step(0, 0, 0, 16'h0007, 32'h0, 1, 32'h55555555, "rd7_new");

    // Reset suppresses a concurrent write and keeps contents.
    step(0, 0, 1, 16'h0002, 32'h00000011, 1, 32'h0, "wr2_setup");
    step(0, 0, 0, 16'h0007, 32'h0, 1, 32'h55555555, "rd7_prerst");
    step(0, 1, 1, 16'h0002, 32'h00000022, 1, 32'h0, "rst_with_write");
    step(0, 0, 0, 16'h0002, 32'h0, 1, 32'h00000011, "rd2_kept");

    // Address extremes: no aliasing between 0xFFFF and 0x0000.
    step(0, 0, 1, 16'hFFFF, 32'hCAFEF00D, 1, 32'h00000000, "wr_top");
    step(0, 0, 1, 16'h0000, 32'h00000001, 1, 32'h0, "wr_bottom");
    step(0, 0, 0, 16'hFFFF, 32'h0, 1, 32'hCAFEF00D, "rd_top");
    step(0, 0, 0, 16'h0000, 32'h0, 1, 32'h00000001, "rd_bottom");

    // Consecutive writes to one address: last wins.
    step(0, 0, 1, 16'h0009, 32'h00000001, 1, 32'h0, "wr9_first");
    step(0, 0, 1, 16'h0009, 32'h00000002, 1, 32'h00000001, "wr9_second");
    step(0, 0, 0, 16'h0009, 32'h0, 1, 32'h00000002, "rd9_last_wins");

    // Non-power-of-two instance: out-of-range writes ignored, reads give zero.
    step(1, 1, 0, 16'h0000, 32'h0, 1, 32'h0, "s_reset");
    step(1, 0, 1, 16'h0002, 32'h00000077, 1, 32'h0, "s_wr2");
    step(1, 0, 1, 16'h000C, 32'h000000FF, 1, 32'h0, "s_wr12_oor");
    step(1, 0, 0, 16'h0002, 32'h0, 1, 32'h00000077, "s_rd2");
    step(1, 0, 0, 16'h000C, 32'h0, 1, 32'h0, "s_rd12_zero");
    step(1, 0, 0, 16'h0004, 32'h0, 1, 32'h0, "s_rd4_no_alias");
    step(1, 0, 1, 16'h0009, 32'h00000005, 1, 32'h0, "s_wr9_last");
    step(1, 0, 0, 16'h0009, 32'h0, 1, 32'h00000005, "s_rd9");
    step(1, 0, 0, 16'h000F, 32'h0, 1, 32'h0, "s_rd15_zero");
    step(1, 0, 0, 16'h0002, 32'h0, 1, 32'h00000077, "s_rd2_unchanged");

    // Let the monitor drain, then confirm every expectation was retired.
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b0; we_b = 1'b0; rst_s = 1'b0; we_s = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
